// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative multiply/divide unit with architectural HI/LO registers
`timescale 1ns/1ps

module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             abort,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;     // multiply: {partial product, multiplier}; divide: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   r_b;       // multiplicand or divisor magnitude
  logic               r_is_div;
  logic               r_neg_res; // product/quotient needs negation (signed op, operand signs differ)
  logic               r_neg_rem; // remainder takes the sign of a negative dividend
  logic               r_div0;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic [WIDTH-1:0]   w_rs_mag;
  logic [WIDTH-1:0]   w_rt_mag;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  // Operand magnitudes; the most-negative value maps onto itself, which is its correct unsigned magnitude
  assign w_rs_mag = (op[0] && rs_data[WIDTH-1]) ? -rs_data : rs_data;
  assign w_rt_mag = (op[0] && rt_data[WIDTH-1]) ? -rt_data : rt_data;

  // One shift-add step: add multiplicand to the upper half when the current multiplier bit is set
  assign w_add = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});

  // One restoring step: shift the next dividend bit into the WIDTH+1-bit partial remainder and trial-subtract
  assign w_shift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff  = w_shift - {1'b0, r_b};

  // Sign correction applied in FIX; divide-by-zero forces an all-ones quotient regardless of signs
  assign w_prod = r_neg_res ? -r_acc : r_acc;
  assign w_quo  = r_div0 ? {WIDTH{1'b1}} : (r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
  assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: abort returns to IDLE from any busy state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN: begin
        if (abort)               w_next = S_IDLE;
        else if (r_cnt == '0)    w_next = S_FIX;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: operand latch, iterations, write-back and direct HI/LO writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_b       <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mthi) r_hi <= wdata;
          if (mtlo) r_lo <= wdata;
          if (start) begin
            r_acc     <= {{WIDTH{1'b0}}, w_rs_mag};
            r_b       <= w_rt_mag;
            r_is_div  <= op[1];
            r_neg_res <= op[0] & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            r_neg_rem <= op[0] & rs_data[WIDTH-1];
            r_div0    <= (rt_data == '0);
            r_cnt     <= CW'(WIDTH-1);
          end
        end
        S_RUN: begin
          if (!abort) begin
            r_cnt <= r_cnt - CW'(1);
            if (!r_is_div)
              r_acc <= {w_add, r_acc[WIDTH-1:1]};
            else if (!w_diff[WIDTH])
              r_acc <= {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            else
              r_acc <= {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
          end
        end
        S_FIX: begin
          if (!abort) begin
            r_done <= 1'b1;
            if (r_is_div) begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end else begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit (WIDTH=32)
`timescale 1ns/1ps

module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        abort = 1'b0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .abort(abort),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Present an operation at a falling edge and release start just after the accepting rising edge
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count busy cycles until done is seen; returns at the falling edge inside the done cycle
  task automatic wait_done(output int busy_cycles, output bit seen);
    busy_cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 00000000", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 00000000", lo); end
    rst_n = 1'b1;
  endtask

  task automatic test_multu();
    int  bc;
    bit  seen;
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(bc, seen);
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL multu_done: got %b want 1", seen); end
    n_checks++; if (bc != 33) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d want 33", bc); end
    n_checks++; if (hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
    n_checks++; if (lo !== 32'h00000001) begin n_fail++; $display("FAIL multu_lo: got %h want 00000001", lo); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL multu_busy_in_done: got %b want 0", busy); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL multu_done_single: got %b want 0", done); end
  endtask

  task automatic test_mult_back_to_back();
    int  bc;
    bit  seen;
    issue(2'b01, 32'hFFFFFFFD, 32'h00000005);
    wait_done(bc, seen);
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL mult_done: got %b want 1", seen); end
    n_checks++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    n_checks++; if (lo !== 32'hFFFFFFF1) begin n_fail++; $display("FAIL mult_lo: got %h want fffffff1", lo); end
    op = 2'b01; rs_data = 32'h80000000; rt_data = 32'h80000000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy %b want 1", busy); end
    wait_done(bc, seen);
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b want 1", seen); end
    n_checks++; if (bc != 33) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d want 33", bc); end
    n_checks++; if (hi !== 32'h40000000) begin n_fail++; $display("FAIL b2b_hi: got %h want 40000000", hi); end
    n_checks++; if (lo !== 32'h00000000) begin n_fail++; $display("FAIL b2b_lo: got %h want 00000000", lo); end
  endtask

  task automatic test_div();
    int  bc;
    bit  seen;
    issue(2'b11, 32'hFFFFFFF9, 32'h00000002);
    wait_done(bc, seen);
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL div_neg_done: got %b want 1", seen); end
    n_checks++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_neg_lo: got %h want fffffffd", lo); end
    n_checks++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_neg_hi: got %h want ffffffff", hi); end
    issue(2'b10, 32'h00000007, 32'h00000002);
    wait_done(bc, seen);
    n_checks++; if (lo !== 32'h00000003) begin n_fail++; $display("FAIL divu_lo: got %h want 00000003", lo); end
    n_checks++; if (hi !== 32'h00000001) begin n_fail++; $display("FAIL divu_hi: got %h want 00000001", hi); end
    issue(2'b11, 32'h80000000, 32'hFFFFFFFF);
    wait_done(bc, seen);
    n_checks++; if (lo !== 32'h80000000) begin n_fail++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
    n_checks++; if (hi !== 32'h00000000) begin n_fail++; $display("FAIL div_ovf_hi: got %h want 00000000", hi); end
  endtask

  task automatic test_div_zero();
    int  bc;
    bit  seen;
    issue(2'b10, 32'h00000064, 32'h00000000);
    wait_done(bc, seen);
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL div0_done: got %b want 1", seen); end
    n_checks++; if (bc != 33) begin n_fail++; $display("FAIL div0_busy_cycles: got %0d want 33", bc); end
    n_checks++; if (hi !== 32'h00000064) begin n_fail++; $display("FAIL div0_hi: got %h want 00000064", hi); end
    n_checks++; if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div0_lo: got %h want ffffffff", lo); end
    issue(2'b11, 32'hFFFFFFF9, 32'h00000000);
    wait_done(bc, seen);
    n_checks++; if (hi !== 32'hFFFFFFF9) begin n_fail++; $display("FAIL div0_signed_hi: got %h want fffffff9", hi); end
    n_checks++; if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div0_signed_lo: got %h want ffffffff", lo); end
  endtask

  task automatic test_abort();
    int n_done;
    int n_busy;
    @(negedge clk);
    mthi = 1'b1; wdata = 32'h11;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b1; wdata = 32'h22;
    @(negedge clk);
    mtlo = 1'b0;
    n_checks++; if (hi !== 32'h11) begin n_fail++; $display("FAIL mthi_write: got %h want 00000011", hi); end
    n_checks++; if (lo !== 32'h22) begin n_fail++; $display("FAIL mtlo_write: got %h want 00000022", lo); end
    issue(2'b00, 32'h3, 32'h4);
    @(negedge clk);
    mthi = 1'b1; wdata = 32'h55; start = 1'b1; op = 2'b00; rs_data = 32'h9; rt_data = 32'h9;
    @(negedge clk);
    mthi = 1'b0; start = 1'b0;
    repeat (8) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++; if (hi !== 32'h11) begin n_fail++; $display("FAIL abort_hi: got %h want 00000011", hi); end
    n_checks++; if (lo !== 32'h22) begin n_fail++; $display("FAIL abort_lo: got %h want 00000022", lo); end
    n_done = 0;
    n_busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) n_done++;
      if (busy) n_busy++;
    end
    n_checks++; if (n_done != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", n_done); end
    n_checks++; if (n_busy != 0) begin n_fail++; $display("FAIL abort_no_queued_start: got %0d busy cycles want 0", n_busy); end
    n_checks++; if (hi !== 32'h11) begin n_fail++; $display("FAIL abort_hi_later: got %h want 00000011", hi); end
  endtask

  task automatic test_reset_mid_run();
    int  bc;
    bit  seen;
    issue(2'b11, 32'hFFFFFF9C, 32'h00000007);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b want 0", done); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL rst_mid_hi: got %h want 00000000", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL rst_mid_lo: got %h want 00000000", lo); end
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'b00, 32'h6, 32'h7);
    wait_done(bc, seen);
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL post_rst_done: got %b want 1", seen); end
    n_checks++; if (lo !== 32'd42) begin n_fail++; $display("FAIL post_rst_lo: got %h want 0000002a", lo); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL post_rst_hi: got %h want 00000000", hi); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult_back_to_back();
    test_div();
    test_div_zero();
    test_abort();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
